// File: rtl/mips_main_if.sv
// Instruction-supply / observation bus of the mips_main pipelined core.
interface mips_main_if #(
  parameter int unsigned IMEM_BYTES = 256
);
  logic [7:0]  instruction_mem [IMEM_BYTES];
  logic [31:0] next_instruction;
  logic [31:0] alu_result;

  // Environment side: provides instruction bytes and watches the core.
  modport master (
    output instruction_mem,
    input  next_instruction,
    input  alu_result
  );

  // Core side.
  modport slave (
    input  instruction_mem,
    output next_instruction,
    output alu_result
  );
endinterface

// File: rtl/mips_main.sv
// Five-stage MIPS-subset core (IF/ID/EX/MEM/WB) without forwarding or interlocks.
module mips_main #(
  parameter int unsigned IMEM_BYTES = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic       clk,
  input  logic       reset,
  mips_main_if.slave bus
);
  localparam int unsigned PC_W  = $clog2(IMEM_BYTES);
  localparam int unsigned DM_AW = $clog2(DMEM_WORDS);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  logic [PC_W-1:0] pc_q;
  logic [XLEN-1:0] fetch_word;

  logic [XLEN-1:0] ifid_instr_q;

  alu_op_e         idex_alu_q, idex_alu_d;
  logic            idex_use_imm_q, idex_use_imm_d;
  logic            idex_wr_en_q, idex_wr_en_d;
  logic            idex_mem_rd_q, idex_mem_rd_d;
  logic            idex_mem_wr_q, idex_mem_wr_d;
  logic [RA_W-1:0] idex_wr_addr_q, idex_wr_addr_d;
  logic [XLEN-1:0] idex_rs_val_q, idex_rs_val_d;
  logic [XLEN-1:0] idex_rt_val_q, idex_rt_val_d;
  logic [XLEN-1:0] idex_imm_q, idex_imm_d;

  logic [XLEN-1:0] exmem_alu_q, exmem_alu_d;
  logic [XLEN-1:0] exmem_rt_val_q;
  logic            exmem_wr_en_q, exmem_mem_rd_q, exmem_mem_wr_q;
  logic [RA_W-1:0] exmem_wr_addr_q;

  logic [XLEN-1:0] memwb_data_q, memwb_data_d;
  logic            memwb_wr_en_q;
  logic [RA_W-1:0] memwb_wr_addr_q;

  logic [XLEN-1:0] rf_q   [NREGS];
  logic [XLEN-1:0] dmem_q [DMEM_WORDS];

  logic [5:0]      id_op, id_funct;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic [XLEN-1:0] alu_b;
  logic [DM_AW-1:0] dm_idx;

  // The shift-amount field is never used by the supported subset.
  logic unused_shamt;
  assign unused_shamt = ^ifid_instr_q[10:6];

  // Little-endian combinational fetch; byte addresses wrap with the PC width.
  assign fetch_word = {bus.instruction_mem[pc_q + PC_W'(3)],
                       bus.instruction_mem[pc_q + PC_W'(2)],
                       bus.instruction_mem[pc_q + PC_W'(1)],
                       bus.instruction_mem[pc_q]};

  assign bus.next_instruction = fetch_word;
  assign bus.alu_result       = exmem_alu_q;

  assign id_op    = ifid_instr_q[31:26];
  assign id_rs    = ifid_instr_q[25:21];
  assign id_rt    = ifid_instr_q[20:16];
  assign id_rd    = ifid_instr_q[15:11];
  assign id_funct = ifid_instr_q[5:0];

  // Decode: unsupported encodings fall through as NOP with no side effects.
  always_comb begin
    idex_alu_d     = ALU_NOP;
    idex_use_imm_d = 1'b0;
    idex_wr_en_d   = 1'b0;
    idex_mem_rd_d  = 1'b0;
    idex_mem_wr_d  = 1'b0;
    idex_wr_addr_d = '0;
    case (id_op)
      OP_RTYPE: begin
        idex_wr_addr_d = id_rd;
        idex_wr_en_d   = 1'b1;
        case (id_funct)
          FN_ADD:  idex_alu_d = ALU_ADD;
          FN_SUB:  idex_alu_d = ALU_SUB;
          FN_AND:  idex_alu_d = ALU_AND;
          FN_OR:   idex_alu_d = ALU_OR;
          FN_SLT:  idex_alu_d = ALU_SLT;
          default: idex_wr_en_d = 1'b0;
        endcase
      end
      OP_ADDI: begin
        idex_alu_d     = ALU_ADD;
        idex_use_imm_d = 1'b1;
        idex_wr_en_d   = 1'b1;
        idex_wr_addr_d = id_rt;
      end
      OP_LW: begin
        idex_alu_d     = ALU_ADD;
        idex_use_imm_d = 1'b1;
        idex_wr_en_d   = 1'b1;
        idex_mem_rd_d  = 1'b1;
        idex_wr_addr_d = id_rt;
      end
      OP_SW: begin
        idex_alu_d     = ALU_ADD;
        idex_use_imm_d = 1'b1;
        idex_mem_wr_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Register reads with $0 hardwired to zero; no write-to-read bypass.
  assign idex_rs_val_d = (id_rs == '0) ? '0 : rf_q[id_rs];
  assign idex_rt_val_d = (id_rt == '0) ? '0 : rf_q[id_rt];
  assign idex_imm_d    = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  // Execute: wrapping two's-complement ALU; NOP yields zero.
  always_comb begin
    alu_b       = idex_use_imm_q ? idex_imm_q : idex_rt_val_q;
    exmem_alu_d = '0;
    case (idex_alu_q)
      ALU_ADD: exmem_alu_d = idex_rs_val_q + alu_b;
      ALU_SUB: exmem_alu_d = idex_rs_val_q - alu_b;
      ALU_AND: exmem_alu_d = idex_rs_val_q & alu_b;
      ALU_OR:  exmem_alu_d = idex_rs_val_q | alu_b;
      ALU_SLT: exmem_alu_d = ($signed(idex_rs_val_q) < $signed(alu_b)) ? XLEN'(1) : '0;
      default: exmem_alu_d = '0;
    endcase
  end

  // Memory: word-per-address data memory read combinationally for lw.
  assign dm_idx       = exmem_alu_q[DM_AW-1:0];
  assign memwb_data_d = exmem_mem_rd_q ? dmem_q[dm_idx] : exmem_alu_q;

  // PC and pipeline registers; reset flushes every stage to a NOP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q            <= '0;
      ifid_instr_q    <= '0;
      idex_alu_q      <= ALU_NOP;
      idex_use_imm_q  <= 1'b0;
      idex_wr_en_q    <= 1'b0;
      idex_mem_rd_q   <= 1'b0;
      idex_mem_wr_q   <= 1'b0;
      idex_wr_addr_q  <= '0;
      idex_rs_val_q   <= '0;
      idex_rt_val_q   <= '0;
      idex_imm_q      <= '0;
      exmem_alu_q     <= '0;
      exmem_rt_val_q  <= '0;
      exmem_wr_en_q   <= 1'b0;
      exmem_mem_rd_q  <= 1'b0;
      exmem_mem_wr_q  <= 1'b0;
      exmem_wr_addr_q <= '0;
      memwb_data_q    <= '0;
      memwb_wr_en_q   <= 1'b0;
      memwb_wr_addr_q <= '0;
    end else begin
      pc_q            <= pc_q + PC_W'(4);
      ifid_instr_q    <= fetch_word;
      idex_alu_q      <= idex_alu_d;
      idex_use_imm_q  <= idex_use_imm_d;
      idex_wr_en_q    <= idex_wr_en_d;
      idex_mem_rd_q   <= idex_mem_rd_d;
      idex_mem_wr_q   <= idex_mem_wr_d;
      idex_wr_addr_q  <= idex_wr_addr_d;
      idex_rs_val_q   <= idex_rs_val_d;
      idex_rt_val_q   <= idex_rt_val_d;
      idex_imm_q      <= idex_imm_d;
      exmem_alu_q     <= exmem_alu_d;
      exmem_rt_val_q  <= idex_rt_val_q;
      exmem_wr_en_q   <= idex_wr_en_q;
      exmem_mem_rd_q  <= idex_mem_rd_q;
      exmem_mem_wr_q  <= idex_mem_wr_q;
      exmem_wr_addr_q <= idex_wr_addr_q;
      memwb_data_q    <= memwb_data_d;
      memwb_wr_en_q   <= exmem_wr_en_q;
      memwb_wr_addr_q <= exmem_wr_addr_q;
    end
  end

  // Register file write at the edge ending WB; writes to $0 are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (memwb_wr_en_q && (memwb_wr_addr_q != '0)) begin
      rf_q[memwb_wr_addr_q] <= memwb_data_q;
    end
  end

  // Data memory write for sw at the edge ending MEM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else if (exmem_mem_wr_q) begin
      dmem_q[dm_idx] <= exmem_rt_val_q;
    end
  end
endmodule

// File: tb/tb_mips_main.sv
// Self-checking bench for mips_main: program tables streamed into instruction memory,
// expected ALU results queued at fetch and compared three cycles later.
module tb_mips_main;
  localparam int unsigned IMEM_BYTES = 256;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_alu;
    logic [31:0] exp_rerun;
  } vec_t;

  typedef struct {
    int          due;
    bit          chk;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  mips_main_if #(.IMEM_BYTES(IMEM_BYTES)) bus ();

  mips_main #(.IMEM_BYTES(IMEM_BYTES), .DMEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  vec_t        p1[$];
  vec_t        p3[$];
  logic [31:0] shadow [64];
  int          cyc;
  int          pc_m;
  int          checks;
  int          failures;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic add1(input logic [31:0] instr, input logic [31:0] exp);
    p1.push_back('{instr, exp, exp});
  endtask

  task automatic add3(input logic [31:0] instr, input logic [31:0] exp,
                      input logic [31:0] exp2);
    p3.push_back('{instr, exp, exp2});
  endtask

  task automatic put_word(input int pc, input logic [31:0] w);
    bus.instruction_mem[pc]     = w[7:0];
    bus.instruction_mem[pc + 1] = w[15:8];
    bus.instruction_mem[pc + 2] = w[23:16];
    bus.instruction_mem[pc + 3] = w[31:24];
    shadow[pc / 4] = w;
  endtask

  // One fetch cycle: optionally place the word, check fetch and any due ALU result.
  task automatic step(input logic [31:0] instr, input logic [31:0] exp_alu,
                      input bit chk, input bit wr);
    exp_t e;
    if (wr) put_word(pc_m, instr);
    #1;
    check($sformatf("next_instruction cyc%0d pc%0d", cyc, pc_m), bus.next_instruction,
          shadow[pc_m / 4]);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.chk) check($sformatf("alu_result cyc%0d", cyc), bus.alu_result, e.val);
    end
    sb.push_back('{cyc + 3, chk, exp_alu});
    @(negedge clk);
    cyc++;
    pc_m = (pc_m + 4) % IMEM_BYTES;
  endtask

  // Start of a fresh run after reset: the flushed pipeline shows zero for three cycles.
  task automatic restart();
    sb.delete();
    cyc  = 0;
    pc_m = 0;
    for (int i = 0; i < 3; i++) sb.push_back('{i, 1'b1, 32'h0});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    pc_m     = 0;
    for (int i = 0; i < 256; i++) bus.instruction_mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;

    // Phase 1 program: arithmetic, memory, hazard and edge cases.
    add1(itype(6'h08, 0, 10, 10), 32'd10);            // 0  addi $10,$0,10
    add1(itype(6'h08, 0, 12, 11), 32'd11);            // 1  addi $12,$0,11
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);     // 2-4
    add1(rtype(12, 10, 11, 6'h20), 32'd21);           // 5  add $11,$12,$10
    add1(rtype(12, 10, 13, 6'h22), 32'd1);            // 6  sub $13,$12,$10
    add1(rtype(10, 12, 14, 6'h24), 32'd10);           // 7  and $14,$10,$12
    add1(rtype(12, 10, 15, 6'h25), 32'd11);           // 8  or  $15,$12,$10
    add1(itype(6'h2B, 10, 11, 0), 32'd10);            // 9  sw $11,0($10)
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);     // 10-12
    add1(itype(6'h23, 10, 16, 0), 32'd10);            // 13 lw $16,0($10)
    for (int i = 0; i < 4; i++) add1(NOP, 32'd0);     // 14-17
    add1(rtype(16, 0, 20, 6'h20), 32'd21);            // 18 $16 via alu
    add1(rtype(13, 0, 21, 6'h20), 32'd1);             // 19 $13
    add1(rtype(14, 0, 22, 6'h20), 32'd10);            // 20 $14
    add1(rtype(15, 0, 23, 6'h20), 32'd11);            // 21 $15
    add1(itype(6'h08, 0, 1, 5), 32'd5);               // 22 addi $1,$0,5
    add1(rtype(1, 1, 2, 6'h20), 32'd0);               // 23 add $2,$1,$1 reads stale $1
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);     // 24-26
    add1(rtype(2, 0, 17, 6'h20), 32'd0);              // 27 $2 stayed 0
    add1(itype(6'h08, 0, 6, 5), 32'd5);               // 28 addi $6,$0,5
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);     // 29-31
    add1(rtype(6, 6, 7, 6'h20), 32'd10);              // 32 add $7,$6,$6
    add1(itype(6'h08, 0, 0, 7), 32'd7);               // 33 addi $0,$0,7
    add1(itype(6'h08, 0, 3, -1), 32'hFFFF_FFFF);      // 34 addi $3,$0,-1
    for (int i = 0; i < 2; i++) add1(NOP, 32'd0);     // 35-36
    add1(rtype(0, 10, 18, 6'h20), 32'd10);            // 37 $0 still zero
    add1(rtype(3, 0, 4, 6'h2A), 32'd1);               // 38 slt $4,$3,$0
    add1(itype(6'h2B, 0, 7, 20), 32'd20);             // 39 sw $7,20($0)
    add1(itype(6'h23, 0, 9, 20), 32'd20);             // 40 lw $9,20($0) right after sw
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);     // 41-43
    add1(rtype(9, 0, 19, 6'h20), 32'd10);             // 44 $9 got stored 10
    add1(itype(6'h08, 3, 24, 1), 32'd0);              // 45 0xFFFFFFFF+1 wraps
    add1(rtype(4, 0, 25, 6'h20), 32'd1);              // 46 $4
    add1(itype(6'h08, 0, 26, 16'h4000), 32'h4000);    // 47 addi $26,$0,0x4000
    add1(32'h0003_2900, 32'd0);                       // 48 sll $5,$3,4 -> NOP
    add1(itype(6'h0F, 0, 5, 16'h1234), 32'd0);        // 49 unsupported op -> NOP
    add1(NOP, 32'd0);                                 // 50
    for (int k = 0; k < 16; k++) begin                // 51..114 doubling chain
      add1(rtype(26, 26, 26, 6'h20), 32'(32'h4000 << (k + 1)));
      if (k == 0) begin
        add1(NOP, 32'd0);
        add1(rtype(5, 10, 31, 6'h20), 32'd10);        // 53 $5 untouched by NOPs
        add1(NOP, 32'd0);
      end else begin
        for (int i = 0; i < 3; i++) add1(NOP, 32'd0);
      end
    end
    add1(itype(6'h08, 26, 27, -1), 32'h3FFF_FFFF);    // 115
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);
    add1(rtype(26, 27, 28, 6'h20), 32'h7FFF_FFFF);    // 119
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);
    add1(rtype(28, 25, 29, 6'h20), 32'h8000_0000);    // 123 0x7FFFFFFF+1
    for (int i = 0; i < 3; i++) add1(NOP, 32'd0);
    add1(rtype(29, 0, 30, 6'h2A), 32'd1);             // 127 slt of 0x80000000 < 0

    // Phase 3 program: 64 words after a mid-run reset, then re-executed after PC wrap.
    add3(itype(6'h23, 0, 5, 10), 32'd10, 32'd10);     // lw $5,10($0)
    add3(rtype(11, 0, 8, 6'h20), 32'd0, 32'd0);       // $11 cleared
    add3(rtype(7, 0, 9, 6'h20), 32'd0, 32'd0);        // $7 cleared
    add3(rtype(16, 4, 13, 6'h25), 32'd0, 32'd0);      // $16,$4 cleared
    add3(NOP, 32'd0, 32'd0);
    add3(rtype(5, 0, 24, 6'h20), 32'd0, 32'd0);       // DMEM[10] cleared
    add3(itype(6'h08, 1, 1, 1), 32'd1, 32'd2);        // addi $1,$1,1 counts passes
    while (p3.size() < 64) add3(NOP, 32'd0, 32'd0);

    // Initial reset, held for two edges.
    put_word(0, 32'h200A_000A);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset alu_result", bus.alu_result, 32'h0);
    check("reset next_instruction", bus.next_instruction, 32'h200A_000A);
    reset = 1'b1;
    restart();

    foreach (p1[i]) step(p1[i].instr, p1[i].exp_alu, 1'b1, 1'b1);
    // Let the last results retire, then run through a PC wrap unchecked for ALU.
    for (int i = 0; i < 67; i++) step(NOP, 32'd0, 1'b0, 1'b0);

    // Mid-run reset discards in-flight work and clears state.
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("midreset alu_result", bus.alu_result, 32'h0);
    check("midreset next_instruction", bus.next_instruction, shadow[0]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    // The edge just taken had reset high only if released before it; keep a clean restart.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    restart();

    foreach (p3[i]) step(p3[i].instr, p3[i].exp_alu, 1'b1, 1'b1);
    foreach (p3[i]) step(p3[i].instr, p3[i].exp_rerun, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(NOP, 32'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_main.md
Name: mips_main

Overview:
- Five-stage pipelined MIPS-subset integer core: IF, ID, EX, MEM, WB.
- The byte-wide instruction memory is supplied as an input array.
- Exposes the fetched instruction word and the registered ALU result for observation.
- No forwarding and no hazard detection: software inserts NOPs. A consumer must sit at least 4 instructions after its producer.

Parameters:
- IMEM_BYTES, 256, depth of the instruction byte array; the PC wraps modulo this value.
- DMEM_WORDS, 256, data memory depth in 32-bit words, indexed by address[7:0].

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clk.
- next_instruction  output  32  instruction word at the current PC (combinational fetch).
- alu_result  output  32  ALU result held in the EX/MEM pipeline register.
- instruction_mem  input  8 x 256 (unpacked)  instruction bytes, little-endian.

Behaviour:
- Reset (reset==0 at posedge):
  - PC=0.
  - All pipeline registers cleared to a NOP/zero state with no writes enabled.
  - All 32 registers = 0 and all data memory words = 0.
  - alu_result=0 from the next cycle. next_instruction shows the word at address 0.
  - Reset mid-operation discards all in-flight instructions.
- Fetch: word = {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}, byte indices mod 256. next_instruction equals this word.
- PC: increments by 4 each cycle; PC is 8 bits and wraps from 252 to 0. No branches or jumps.
- Decode: fields op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]. imm is sign-extended to 32 bits.
- Register file: 32x32. Two combinational reads in ID, one write at the posedge ending WB. There is no write-to-read bypass, so a value written at the edge that ends cycle n is first readable in ID during cycle n+1.
- Register $0 reads as 0 and writes to it are ignored.
- Supported instructions (all others, including all-zero words, execute as NOP with no register or memory write):
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed). Destination is rd.
  - addi (op 0x08): rt = rs + sext(imm).
  - lw (op 0x23): rt = DMEM[(rs + sext(imm))[7:0]].
  - sw (op 0x2B): DMEM[(rs + sext(imm))[7:0]] = rt.
  - sll with funct 0 is treated as NOP.
- Arithmetic: 32-bit two's complement, wrap on overflow, no exceptions.
- Memory stage:
  - sw writes at the posedge ending MEM.
  - lw reads DMEM combinationally in MEM. A lw immediately after a sw to the same address sees the stored value.
  - Unaligned addresses are legal; each address is one word.
- Timing: an instruction fetched in cycle n is in ID n+1, EX n+2, MEM n+3, WB n+4. Its ALU result appears on alu_result during cycle n+3.
- For lw and sw, alu_result shows the effective address. For NOP it shows 0.
- Dependency rule: a consumer fetched at cycle ≥ n+4 reads a producer's (fetched at n) value. Closer consumers read the stale value; this is defined behaviour, not an error.

Test Plan:
- Reset held low 2 cycles, then released -> PC=0, alu_result=0. next_instruction = 0x200A000A when bytes 3..0 = 20,0A,00,0A.
- Program: addi $10,$0,10; addi $12,$0,11; 3 NOPs; add $11,$12,$10; sub $13,$12,$10; and $14,$10,$12; or $15,$12,$10.
  -> alu_result sequence 10, 11, 0, 0, 0, 21, 1, 10, 11.
  -> Final registers: $11=21, $13=1, $14=10, $15=11.
- Continue with sw $11,0($10); 3 NOPs; lw $16,0($10).
  -> alu_result 10 for both. DMEM[10]=21. $16=21 after WB.
  -> next_instruction reads 0 for 4 consecutive cycles after the lw is fetched.
- Hazard: addi $1,$0,5 followed directly by add $2,$1,$1 -> $2=0, confirming no forwarding. The same pair with 3 NOPs between gives $2=10.
- Edge cases:
  - addi $0,$0,7 -> $0 stays 0.
  - addi $3,$0,-1 -> $3=0xFFFFFFFF.
  - slt $4,$3,$0 -> $4=1.
  - add of 0x7FFFFFFF+1 -> 0x80000000.
- Wrap and reset: run 64+ cycles -> PC wraps to 0 and the program re-executes. Asserting reset mid-program clears all registers, DMEM and alu_result on the next edge.
